// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives instruction_memory reads from the PC and buffers fetched
// words in a 2-entry valid/ready FIFO, with redirect flush and halt/start control.
module fetch_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                MEM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               busy,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, inflight_pc_q;
    logic                inflight_q;
    logic [1:0]          count_q, count_d;
    logic                wr_q, rd_q;
    logic [INSTR_W-1:0]  instr_q [2];
    logic [ADDR_W-1:0]   ipc_q [2];
    logic                flush, pop, push, issue;

    assign flush     = redirect_valid && state_q != IDLE;
    assign out_valid = count_q != 2'd0;
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !flush;
    // A pop this cycle frees a slot for the word that this issue will return next cycle
    assign issue     = state_q == FETCH && !halt_req && !flush &&
                       (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign out_instr = instr_q[rd_q];
    assign out_pc    = ipc_q[rd_q];
    assign busy      = state_q == FETCH || state_q == DRAIN || inflight_q;
    assign state_o   = state_q;

    always_comb begin
        state_d = state_q == IDLE  && start       ? FETCH :
                  state_q == FETCH && halt_req    ? DRAIN :
                  state_q == DRAIN && !inflight_q ? HALT  :
                  state_q == HALT  && start       ? FETCH : state_q;
        pc_d    = state_q == IDLE && start ? RESET_PC :
                  flush ? redirect_pc % ADDR_W'(MEM_DEPTH) :
                  issue ? (pc_q == ADDR_W'(MEM_DEPTH - 1) ? '0 : pc_q + 1'b1) : pc_q;
        count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            count_q    <= count_d;
            if (issue)
                inflight_pc_q <= pc_q;
            if (flush) begin
                wr_q <= 1'b0;
                rd_q <= 1'b0;
            end else begin
                if (push) begin
                    instr_q[wr_q] <= imem_instr;
                    ipc_q[wr_q]   <= inflight_pc_q;
                    wr_q          <= ~wr_q;
                end
                if (pop)
                    rd_q <= ~rd_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer against a mem[i]=3*i model
// with MEM_DEPTH=16, covering throughput, backpressure, redirect, halt, wrap and reset.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, halt_req, redirect_valid, out_ready;
    logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
    logic        imem_en, out_valid, busy;
    logic [1:0]  state_o;
    int          n_checks = 0, n_fail = 0, ndeliv = 0, exp_pc = 0, last_pc = -1, n;

    fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'd0), .MEM_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_en) imem_instr <= 32'(imem_addr[3:0]) * 32'd3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (!reset && out_valid && out_ready) begin
            check("deliv_pc", 64'(out_pc), 64'(exp_pc));
            check("deliv_instr", 64'(out_instr), 64'(exp_pc * 3));
            last_pc = int'(out_pc);
            exp_pc  = (exp_pc + 1) % 16;
            ndeliv++;
        end

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_en", 64'(imem_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("seq_state", 64'(state_o), 64'd1);
        check("seq_en0", 64'(imem_en), 64'd1);
        check("seq_addr0", 64'(imem_addr), 64'd0);
        tick();
        check("seq_valid1", 64'(out_valid), 64'd0);
        check("seq_busy", 64'(busy), 64'd1);
        check("seq_addr1", 64'(imem_addr), 64'd1);
        tick();
        check("seq_valid2", 64'(out_valid), 64'd1);
        check("seq_head0", 64'(out_pc), 64'd0);
        repeat (5) tick();
        check("seq_rate", 64'(ndeliv), 64'd5);
        check("seq_head5", 64'(out_pc), 64'd5);

        out_ready = 1'b0;
        #1;
        check("bp_en_first", 64'(imem_en), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_head", 64'(out_pc), 64'd5);
            check("bp_en", 64'(imem_en), 64'd0);
        end
        check("bp_nodeliv", 64'(ndeliv), 64'd5);
        out_ready = 1'b1;
        #1;
        check("bp_release_en", 64'(imem_en), 64'd1);
        check("bp_release_addr", 64'(imem_addr), 64'd7);

        for (n = 0; n < 20 && !(out_valid && out_pc == 32'd9); n++) tick();
        check("rd_wait", 64'(n < 20), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd18;
        #1;
        check("rd_en_blocked", 64'(imem_en), 64'd0);
        tick();
        redirect_valid = 1'b0;
        exp_pc = 2;
        #1;
        check("rd_last", 64'(last_pc), 64'd9);
        check("rd_valid0", 64'(out_valid), 64'd0);
        check("rd_addr", 64'(imem_addr), 64'd2);
        check("rd_en", 64'(imem_en), 64'd1);
        repeat (2) tick();
        check("rd_valid", 64'(out_valid), 64'd1);
        check("rd_head", 64'(out_pc), 64'd2);

        for (n = 0; n < 20 && !(imem_en && imem_addr == 32'd8); n++) tick();
        check("halt_wait", 64'(n < 20), 64'd1);
        halt_req = 1'b1;
        #1;
        check("halt_en", 64'(imem_en), 64'd0);
        tick();
        halt_req = 1'b0;
        #1;
        check("halt_drain", 64'(state_o), 64'd2);
        check("halt_drain_busy", 64'(busy), 64'd1);
        tick();
        check("halt_state", 64'(state_o), 64'd3);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_addr", 64'(imem_addr), 64'd8);
        check("halt_en_off", 64'(imem_en), 64'd0);
        repeat (3) tick();
        check("halt_empty", 64'(out_valid), 64'd0);
        check("halt_last", 64'(last_pc), 64'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("resume_state", 64'(state_o), 64'd1);
        check("resume_en", 64'(imem_en), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'd8);

        for (n = 0; n < 20 && !(out_valid && out_pc == 32'd15); n++) tick();
        check("wrap_wait", 64'(n < 20), 64'd1);
        tick();
        check("wrap_head0", 64'(out_pc), 64'd0);
        check("wrap_valid", 64'(out_valid), 64'd1);
        tick();
        check("wrap_head1", 64'(out_pc), 64'd1);

        out_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_en", 64'(imem_en), 64'd0);
        check("arst_addr", 64'(imem_addr), 64'd0);
        check("arst_state", 64'(state_o), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_instr", 64'(out_instr), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 64'(out_valid), 64'd0);
            check("post_rst_state", 64'(state_o), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
